// File: rtl/muldiv_unit.sv
// Multi-cycle HI/LO multiply/divide unit for the execute stage.
// Owns architectural HI/LO; busy drives the hazard-unit stall.
module muldiv_unit #(
  parameter int WIDTH       = 32,
  parameter int MUL_LATENCY = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] rem;
  logic             sgn;
  logic             neg_q;
  logic             neg_r;
  logic             dz;

  logic             accept;
  logic             is_mthi;
  logic             is_mtlo;
  logic             is_mul;
  logic             sa;
  logic             sb;
  logic [WIDTH-1:0] amag;
  logic [WIDTH-1:0] bmag;

  logic [2*WIDTH-1:0] ma;
  logic [2*WIDTH-1:0] mb;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0]     shf;
  logic [WIDTH:0]     dif;
  logic               ge;
  logic [WIDTH-1:0]   nrem;
  logic [WIDTH-1:0]   nquo;

  assign busy    = (state != IDLE);
  assign accept  = start & ~busy & ~flush & (op <= 3'd5);
  assign is_mthi = (op == 3'd4);
  assign is_mtlo = (op == 3'd5);
  assign is_mul  = (op[2:1] == 2'b00);
  assign sa      = (op == 3'd2) & a[WIDTH-1];
  assign sb      = (op == 3'd2) & b[WIDTH-1];
  assign amag    = sa ? -a : a;
  assign bmag    = sb ? -b : b;

  // Low 2W bits of the extended product are exact for both signednesses.
  always_comb begin
    ma   = {{WIDTH{sgn & opa[WIDTH-1]}}, opa};
    mb   = {{WIDTH{sgn & opb[WIDTH-1]}}, opb};
    prod = ma * mb;
    shf  = {rem, opa[WIDTH-1]};
    dif  = shf - {1'b0, opb};
    ge   = ~dif[WIDTH];
    nrem = ge ? dif[WIDTH-1:0] : shf[WIDTH-1:0];
    nquo = {opa[WIDTH-2:0], ge};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      cnt   <= '0;
      opa   <= '0;
      opb   <= '0;
      rem   <= '0;
      sgn   <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dz    <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (accept) begin
              unique case (1'b1)
                is_mthi: begin
                  hi   <= a;
                  done <= 1'b1;
                end
                is_mtlo: begin
                  lo   <= a;
                  done <= 1'b1;
                end
                is_mul: begin
                  opa   <= a;
                  opb   <= b;
                  sgn   <= (op == 3'd0);
                  state <= MUL;
                  cnt   <= CW'(MUL_LATENCY - 1);
                end
                default: begin
                  // opa holds the dividend, shifting out as quotient bits shift in
                  dz    <= (b == '0);
                  opa   <= (b == '0) ? a : amag;
                  opb   <= bmag;
                  rem   <= '0;
                  neg_q <= sa ^ sb;
                  neg_r <= sa;
                  state <= DIV;
                  cnt   <= (b == '0) ? '0 : CW'(WIDTH - 1);
                end
              endcase
            end
          end
          MUL: begin
            if (cnt == '0) begin
              {hi, lo} <= prod;
              state    <= IDLE;
              done     <= 1'b1;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          DIV: begin
            if (cnt == '0) begin
              if (dz) begin
                hi <= opa;
                lo <= '1;
              end else begin
                hi <= neg_r ? -nrem : nrem;
                lo <= neg_q ? -nquo : nquo;
              end
              state <= IDLE;
              done  <= 1'b1;
            end else begin
              opa <= nquo;
              rem <= nrem;
              cnt <= cnt - 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: vector table with a result scoreboard,
// plus hand sequences for flush, reset and back-to-back issue.
module tb_muldiv_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         resetn = 1'b1;
  logic         start = 1'b0;
  logic         flush = 1'b0;
  logic [2:0]   op = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(W), .MUL_LATENCY(2)) dut (
    .clk(clk), .resetn(resetn), .start(start), .op(op),
    .a(a), .b(b), .flush(flush),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  typedef struct packed {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] eh;
    logic [W-1:0] el;
    logic [7:0]   lat;
  } vec_t;

  typedef struct packed {
    logic [W-1:0] h;
    logic [W-1:0] l;
  } exp_t;

  vec_t         vt[15];
  exp_t         sbq[$];
  logic [W-1:0] mh = '0;
  logic [W-1:0] ml = '0;
  int           pass_n = 0;
  int           total_n = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic run_op(input logic [2:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic [W-1:0] eh,
                        input logic [W-1:0] el, input int lat,
                        input string nm);
    exp_t e;
    int   nb;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    sbq.push_back({eh, el});
    mh = eh; ml = el;
    @(negedge clk);
    start = 1'b0;
    nb = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      if (busy) nb++;
      @(negedge clk);
    end
    chk({nm, " done"}, 64'(done), 64'd1);
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      if (done) begin
        chk({nm, " hi"}, 64'(hi), 64'(e.h));
        chk({nm, " lo"}, 64'(lo), 64'(e.l));
      end
    end
    chk({nm, " busy_cycles"}, 64'(nb), 64'(lat));
    chk({nm, " busy_at_done"}, 64'(busy), 64'd0);
    @(negedge clk);
    chk({nm, " pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    int nd;
    vt[0]  = '{3'd0, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 8'd2};
    vt[1]  = '{3'd1, 32'hFFFFFFFD, 32'd5, 32'h00000004, 32'hFFFFFFF1, 8'd2};
    vt[2]  = '{3'd3, 32'd100, 32'd7, 32'h00000002, 32'h0000000E, 8'd32};
    vt[3]  = '{3'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 8'd32};
    vt[4]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 8'd32};
    vt[5]  = '{3'd2, 32'h12345678, 32'd0, 32'h12345678, 32'hFFFFFFFF, 8'd1};
    vt[6]  = '{3'd3, 32'd5, 32'd0, 32'h00000005, 32'hFFFFFFFF, 8'd1};
    vt[7]  = '{3'd4, 32'h0000ABCD, 32'd0, 32'h0000ABCD, 32'hFFFFFFFF, 8'd0};
    vt[8]  = '{3'd5, 32'h00001234, 32'd0, 32'h0000ABCD, 32'h00001234, 8'd0};
    vt[9]  = '{3'd2, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 8'd32};
    vt[10] = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 8'd2};
    vt[11] = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1, 8'd2};
    vt[12] = '{3'd3, 32'hFFFFFFFF, 32'd1, 32'h0, 32'hFFFFFFFF, 8'd32};
    vt[13] = '{3'd2, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFF2, 8'd32};
    vt[14] = '{3'd3, 32'h80000000, 32'h80000000, 32'h0, 32'h1, 8'd32};

    #2 resetn = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset hi", 64'(hi), 64'd0);
    chk("reset lo", 64'(lo), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    resetn = 1'b1;

    for (int i = 0; i < 15; i++)
      run_op(vt[i].op, vt[i].a, vt[i].b, vt[i].eh, vt[i].el,
             int'(vt[i].lat), $sformatf("vec%0d", i));

    // reserved ops leave everything alone
    for (int r = 6; r < 8; r++) begin
      @(negedge clk);
      start = 1'b1; op = 3'(r); a = 32'h5A5A5A5A;
      @(negedge clk);
      start = 1'b0;
      chk("reserved busy", 64'(busy), 64'd0);
      nd = 0;
      for (int i = 0; i < 4; i++) begin
        if (done) nd++;
        @(negedge clk);
      end
      chk("reserved done", 64'(nd), 64'd0);
      chk("reserved hilo", {hi, lo}, {mh, ml});
    end

    // start together with flush is dropped
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 3'd4; a = 32'h11111111;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("flush_start done", 64'(done), 64'd0);
    chk("flush_start busy", 64'(busy), 64'd0);
    chk("flush_start hilo", {hi, lo}, {mh, ml});

    // DIVU in flight, ignored start, then flush on cycle 10
    @(negedge clk);
    start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    nd = 0;
    for (int c = 1; c < 10; c++) begin
      if (done) nd++;
      start = (c == 3);
      op = 3'd4; a = 32'hDEADBEEF;
      @(negedge clk);
    end
    start = 1'b0;
    chk("flush mid busy", 64'(busy), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush busy_after", 64'(busy), 64'd0);
    for (int i = 0; i < 40; i++) begin
      if (done) nd++;
      @(negedge clk);
    end
    chk("flush no_done", 64'(nd), 64'd0);
    chk("flush hilo", {hi, lo}, {mh, ml});

    // flush on the completion edge of a divide by zero
    @(negedge clk);
    start = 1'b1; op = 3'd2; a = 32'h77; b = 32'd0;
    @(negedge clk);
    start = 1'b0; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_cpl done", 64'(done), 64'd0);
    chk("flush_cpl busy", 64'(busy), 64'd0);
    chk("flush_cpl hilo", {hi, lo}, {mh, ml});

    // back-to-back: MTLO accepted in the MULT done cycle
    @(negedge clk);
    start = 1'b1; op = 3'd0; a = 32'hFFFFFFFE; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("b2b mul done", 64'(done), 64'd1);
    chk("b2b mul hilo", {hi, lo}, {32'hFFFFFFFF, 32'hFFFFFFFA});
    start = 1'b1; op = 3'd5; a = 32'h55;
    @(negedge clk);
    start = 1'b0;
    chk("b2b mtlo done", 64'(done), 64'd1);
    chk("b2b mtlo hilo", {hi, lo}, {32'hFFFFFFFF, 32'h00000055});
    mh = 32'hFFFFFFFF; ml = 32'h55;

    // asynchronous reset mid-DIV, between edges
    @(negedge clk);
    start = 1'b1; op = 3'd2; a = 32'd1000; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("arst hi", 64'(hi), 64'd0);
    chk("arst lo", 64'(lo), 64'd0);
    chk("arst busy", 64'(busy), 64'd0);
    chk("arst done", 64'(done), 64'd0);
    mh = '0; ml = '0;
    @(negedge clk);
    resetn = 1'b1;
    run_op(3'd1, 32'd2, 32'd3, 32'd0, 32'd6, 2, "post_reset multu");

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Multi-cycle, parametrised HI/LO multiply/divide unit for the MIPS pipeline. It replaces the single-cycle combinational multiplier beside the execute-stage ALU. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO against its own architectural HI/LO registers. It holds a busy flag so the hazard unit can stall the pipeline, and it accepts a synchronous flush from exception handling.

## Interface

Parameters:
- WIDTH, 32, operand and HI/LO width; even, ≥ 4.
- MUL_LATENCY, 2, cycles from accept to multiply result; ≥ 1.

Ports:
- clk  in  1  single clock; all state is updated on its rising edge.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  request valid this cycle.
- op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 reserved.
- a  in  WIDTH  rs value: multiplicand, dividend, or MTHI/MTLO data.
- b  in  WIDTH  rt value: multiplier or divisor.
- flush  in  1  synchronous abort of any in-flight or incoming operation.
- busy  out  1  operation in flight; new starts are ignored while high.
- done  out  1  one-cycle pulse: HI/LO were just written by a completed operation.
- hi  out  WIDTH  registered HI.
- lo  out  WIDTH  registered LO.

## Operation

- FSM states: IDLE, MUL, DIV. A down-counter of width clog2(WIDTH+1) runs alongside.
- Accept condition: start & !busy & !flush & op ≤ 5. Reserved ops are ignored: no state change and no done.
- MTHI / MTLO:
  - On acceptance, hi (or lo) takes a at the same edge.
  - done pulses in the next cycle.
  - The FSM stays IDLE and busy stays 0.
- MULT / MULTU:
  - Operands are latched and the FSM enters MUL with counter = MUL_LATENCY−1.
  - The 2·WIDTH product may be pipelined internally across MUL_LATENCY stages.
  - The result is {hi, lo} = a × b: signed for MULT, unsigned for MULTU.
- DIV / DIVU:
  - Restoring radix-2 division, one quotient bit per cycle, WIDTH iterations. The FSM enters DIV with counter = WIDTH−1.
  - Signed division works on magnitudes. The quotient truncates toward zero. The quotient is negated if the operand signs differ. The remainder takes the dividend's sign.
  - lo = quotient, hi = remainder.
  - Overflow case (most-negative ÷ −1): lo = most-negative, hi = 0.
  - Divide by zero completes in one cycle (counter = 0), with lo = all ones and hi = a, for both DIV and DIVU.
- Completion: when counter = 0 in MUL or DIV, the following all happen at that edge:
  - hi/lo are written;
  - the FSM returns to IDLE;
  - busy falls;
  - done = 1 for exactly the following cycle.
- flush:
  - When flush = 1, the FSM goes to IDLE at the next edge and busy = 0.
  - hi/lo keep their pre-operation values and no done is issued.
  - flush on the completion edge still wins: hi/lo are not written.
  - flush together with start drops the start.
- Reset (resetn = 0, any time, including mid-operation):
  - hi = 0, lo = 0, busy = 0, done = 0, FSM = IDLE, counter = 0.
  - The in-flight operation is discarded.
- hi/lo change only on completion, on MTHI/MTLO, or on reset.

## Timing

- Accept at edge k:
  - MUL: busy = 1 during cycles k+1 … k+MUL_LATENCY. hi/lo are valid and done = 1 in the cycle after edge k+MUL_LATENCY.
  - DIV: same shape, with WIDTH in place of MUL_LATENCY.
  - Divide by zero: latency 1.
- Back-to-back: a new start is accepted in the cycle done is high, because busy is already 0.
- MTHI/MTLO accepted at edge k: hi/lo are updated at edge k, and done is high in cycle k+1.
- Interaction with the rest of the pipeline:
  - The hazard unit stalls a MFHI/MFLO, or a second muldiv op, while busy = 1.
  - hi/lo are registered outputs with no bypass, so a MFHI issued in the done cycle reads the new value.

## Test plan

- MULT a = −3 (FFFFFFFD), b = 5, WIDTH = 32, MUL_LATENCY = 2 -> busy high for 2 cycles, then hi = FFFFFFFF, lo = FFFFFFF1, done pulses for one cycle; MULTU of the same operands -> hi = 00000004, lo = FFFFFFF1.
- DIVU 100 / 7 -> busy high for exactly 32 cycles, then lo = 0000000E, hi = 00000002; DIV −7 / 2 -> lo = FFFFFFFD, hi = FFFFFFFF; DIV 80000000 / FFFFFFFF -> lo = 80000000, hi = 0.
- DIV 12345678 / 0 -> after 1 cycle: lo = FFFFFFFF, hi = 12345678, done = 1.
- DIVU in flight, flush asserted on cycle 10 -> busy = 0 next cycle, hi/lo unchanged, no done; a start raised while busy -> ignored, no extra done.
- MTHI 0000ABCD, then MTLO 00001234 -> hi = 0000ABCD and lo = 00001234 with one done each, busy never high; op = 6 -> no change, no done.
- resetn pulled low mid-DIV (cycle 5), asynchronously, between edges -> hi = lo = 0 and busy = done = 0 immediately; after release, MULTU 2 × 3 -> lo = 6, hi = 0.
